// File: rtl/dcache_pkg.sv
// Shared dcache definitions: geometry defaults, tag store bit layout and the
// flush engine state encoding.
package dcache_pkg;

  localparam int unsigned DCACHE_NUM_WORDS  = 256;
  localparam int unsigned DCACHE_TAG_WIDTH  = 44;
  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned PLEN              = 56;

  // Tag store word layout: {tag, dirty, valid}
  localparam int unsigned TAG_STORE_VALID_BIT_POSITION = 0;
  localparam int unsigned TAG_STORE_DIRTY_BIT_POSITION = 1;
  localparam int unsigned TAG_STORE_TAG_LSB            = 2;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_INIT_REQ,
    ST_READ,
    ST_CHECK,
    ST_WB,
    ST_INVAL,
    ST_DONE_I,
    ST_DONE_A
  } flush_state_e;

endpackage

// File: rtl/dcache_flush_engine.sv
// Sweeps every dcache index: writes back valid+dirty lines, then clears
// VALID/DIRTY. Runs an invalidate-only sweep out of reset.
module dcache_flush_engine
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = DCACHE_NUM_WORDS,
  parameter int unsigned TAG_WIDTH  = DCACHE_TAG_WIDTH,
  parameter int unsigned LINE_WIDTH = DCACHE_LINE_WIDTH,
  parameter int unsigned ADDR_WIDTH = PLEN
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic                                        inv_only_i,
  output logic                                        busy_o,
  output logic                                        flush_ack_o,
  output logic                                        tag_en_o,
  output logic                                        tag_we_o,
  output logic [$clog2(NUM_WORDS)-1:0]                tag_addr_o,
  output logic [TAG_WIDTH+TAG_STORE_TAG_LSB-1:0]      tag_wdata_o,
  output logic [TAG_WIDTH+TAG_STORE_TAG_LSB-1:0]      tag_bit_en_o,
  input  logic [TAG_WIDTH+TAG_STORE_TAG_LSB-1:0]      tag_rdata_i,
  output logic                                        data_en_o,
  input  logic [LINE_WIDTH-1:0]                       data_rdata_i,
  output logic                                        wb_valid_o,
  input  logic                                        wb_ready_i,
  output logic [ADDR_WIDTH-1:0]                       wb_addr_o,
  output logic [LINE_WIDTH-1:0]                       wb_data_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned TS_W  = TAG_WIDTH + TAG_STORE_TAG_LSB;
  localparam int unsigned OFF_W = ADDR_WIDTH - TAG_WIDTH - IDX_W;
  localparam logic [TS_W-1:0] CLR_MASK =
    TS_W'((1 << TAG_STORE_VALID_BIT_POSITION) | (1 << TAG_STORE_DIRTY_BIT_POSITION));

  flush_state_e            state_q, state_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    pending_q, pending_d;
  logic                    inv_mode_q, inv_mode_d;
  logic [ADDR_WIDTH-1:0]   wb_addr_q, wb_addr_d;
  logic [LINE_WIDTH-1:0]   wb_data_q, wb_data_d;
  logic                    last_idx;
  logic                    start_inv;

  assign last_idx     = (index_q == IDX_W'(NUM_WORDS - 1));
  assign tag_addr_o   = index_q;
  assign tag_wdata_o  = '0;
  assign tag_bit_en_o = CLR_MASK;
  assign wb_addr_o    = wb_addr_q;
  assign wb_data_o    = wb_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      index_q    <= '0;
      pending_q  <= 1'b0;
      inv_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      pending_q  <= pending_d;
      inv_mode_q <= inv_mode_d;
    end
  end

  // Write-back payload needs no reset; it is only observed while wb_valid_o=1.
  always_ff @(posedge clk_i) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    pending_d   = pending_q;
    inv_mode_d  = inv_mode_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    start_inv   = inv_mode_q;
    busy_o      = 1'b1;
    flush_ack_o = 1'b0;
    tag_en_o    = 1'b0;
    tag_we_o    = 1'b0;
    data_en_o   = 1'b0;
    wb_valid_o  = 1'b0;

    // Requests arriving mid-sweep coalesce; the most recent mode wins.
    if (flush_i && (state_q != ST_IDLE)) begin
      pending_d  = 1'b1;
      inv_mode_d = inv_only_i;
    end

    case (state_q)
      ST_INIT, ST_INIT_REQ: begin
        tag_en_o = 1'b1;
        tag_we_o = 1'b1;
        if (last_idx) begin
          state_d = (state_q == ST_INIT) ? ST_DONE_I : ST_DONE_A;
        end else begin
          index_d = index_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        busy_o = pending_q;
        if (flush_i || pending_q) begin
          start_inv  = flush_i ? inv_only_i : inv_mode_q;
          inv_mode_d = start_inv;
          index_d    = '0;
          pending_d  = 1'b0;
          state_d    = start_inv ? ST_INIT_REQ : ST_READ;
        end
      end
      ST_READ: begin
        tag_en_o  = 1'b1;
        data_en_o = 1'b1;
        state_d   = ST_CHECK;
      end
      ST_CHECK: begin
        if (tag_rdata_i[TAG_STORE_VALID_BIT_POSITION] &&
            tag_rdata_i[TAG_STORE_DIRTY_BIT_POSITION]) begin
          wb_addr_d = {tag_rdata_i[TAG_STORE_TAG_LSB +: TAG_WIDTH], index_q, OFF_W'(0)};
          wb_data_d = data_rdata_i;
          state_d   = ST_WB;
        end else begin
          state_d = ST_INVAL;
        end
      end
      ST_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) state_d = ST_INVAL;
      end
      ST_INVAL: begin
        tag_en_o = 1'b1;
        tag_we_o = 1'b1;
        if (last_idx) begin
          state_d = ST_DONE_A;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE_I: state_d = ST_IDLE;
      ST_DONE_A: begin
        flush_ack_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // Keep the stores and memory port quiet while reset is held.
    if (!rst_ni) begin
      busy_o      = 1'b1;
      flush_ack_o = 1'b0;
      tag_en_o    = 1'b0;
      tag_we_o    = 1'b0;
      data_en_o   = 1'b0;
      wb_valid_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Self-checking bench for dcache_flush_engine with a 4-entry behavioural tag/data store.
module tb_dcache_flush_engine;

  localparam int unsigned NW  = 4;
  localparam int unsigned TW  = 8;
  localparam int unsigned LW  = 64;
  localparam int unsigned AW  = 16;
  localparam int unsigned TSW = TW + 2;
  localparam int unsigned IW  = 2;

  logic clk = 1'b0;
  logic rst_ni, flush_i, inv_only_i, wb_ready_i;
  logic busy_o, flush_ack_o, tag_en_o, tag_we_o, data_en_o, wb_valid_o;
  logic [IW-1:0]  tag_addr_o;
  logic [TSW-1:0] tag_wdata_o, tag_bit_en_o, tag_rdata_i;
  logic [LW-1:0]  data_rdata_i, wb_data_o;
  logic [AW-1:0]  wb_addr_o;

  // Store preload port (bench side)
  logic           ld_en;
  logic [IW-1:0]  ld_idx;
  logic [TSW-1:0] ld_ts;
  logic [LW-1:0]  ld_data;
  logic [TSW-1:0] tag_mem [NW];
  logic [LW-1:0]  data_mem [NW];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_flush_engine #(.NUM_WORDS(NW), .TAG_WIDTH(TW), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .inv_only_i(inv_only_i),
    .busy_o(busy_o), .flush_ack_o(flush_ack_o), .tag_en_o(tag_en_o), .tag_we_o(tag_we_o),
    .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o), .tag_bit_en_o(tag_bit_en_o),
    .tag_rdata_i(tag_rdata_i), .data_en_o(data_en_o), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      tag_mem[ld_idx]  <= ld_ts;
      data_mem[ld_idx] <= ld_data;
    end else if (tag_en_o && tag_we_o) begin
      tag_mem[tag_addr_o] <= (tag_mem[tag_addr_o] & ~tag_bit_en_o) | (tag_wdata_o & tag_bit_en_o);
    end
    if (tag_en_o && !tag_we_o) tag_rdata_i <= tag_mem[tag_addr_o];
    if (data_en_o) data_rdata_i <= data_mem[tag_addr_o];
  end

  function automatic logic [TSW-1:0] ts(logic [TW-1:0] t, logic d, logic v);
    return {t, d, v};
  endfunction

  function automatic logic [LW-1:0] pat(int r, int i);
    return 64'hD00D_0000_0000_0000 | LW'(r << 8) | LW'(i);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(int i, logic [TSW-1:0] t, logic [LW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = IW'(i); ld_ts = t; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  typedef struct {
    logic [TSW-1:0] init_ts [NW];
    logic           inv;
    int             stall;
    int             exp_wbs;
    int             exp_lat;
    logic [AW-1:0]  exp_addr0;
    logic [TSW-1:0] exp_ts [NW];
  } vec_t;

  vec_t vecs [5];

  task automatic run_row(input vec_t v, input int r);
    int lat = -1, wbs = 0, stall = 0;
    logic in_wb = 1'b0;
    logic [AW-1:0] a0;
    logic [LW-1:0] d0;
    int idx0;
    for (int i = 0; i < NW; i++) load(i, v.init_ts[i], pat(r, i));
    idx0 = int'(v.exp_addr0[AW-TW-1 -: IW]);
    @(negedge clk);
    flush_i = 1'b1; inv_only_i = v.inv;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      flush_i = 1'b0;
      if (wb_valid_o) begin
        if (!in_wb) begin
          a0 = wb_addr_o; d0 = wb_data_o; in_wb = 1'b1; stall = 0;
          if (wbs == 0) begin
            chk($sformatf("row%0d_wb_addr", r), 64'(wb_addr_o), 64'(v.exp_addr0));
            chk($sformatf("row%0d_wb_data", r), 64'(wb_data_o), 64'(pat(r, idx0)));
          end
        end else begin
          chk($sformatf("row%0d_wb_stable", r), {wb_addr_o, wb_data_o}, {a0, d0});
        end
        if (stall >= v.stall) begin
          wb_ready_i = 1'b1; wbs++; in_wb = 1'b0;
        end else begin
          wb_ready_i = 1'b0; stall++;
        end
      end else begin
        wb_ready_i = 1'b0;
      end
      if (flush_ack_o) begin
        lat = n;
        break;
      end
    end
    chk($sformatf("row%0d_ack_latency", r), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("row%0d_wb_count", r), 64'(wbs), 64'(v.exp_wbs));
    @(negedge clk);
    chk($sformatf("row%0d_busy_after", r), 64'(busy_o), 64'(0));
    for (int i = 0; i < NW; i++)
      chk($sformatf("row%0d_tag%0d", r, i), 64'(tag_mem[i]), 64'(v.exp_ts[i]));
  endtask

  initial begin
    int ack1, ack2, acks, den_after;
    logic saw_wb;

    rst_ni = 1'b0; flush_i = 1'b0; inv_only_i = 1'b0; wb_ready_i = 1'b0;
    ld_en = 1'b0; ld_idx = '0; ld_ts = '0; ld_data = '0;

    // Reset values and automatic invalidate sweep over garbage tags
    for (int i = 0; i < NW; i++) load(i, 10'h3FF, '0);
    #1;
    chk("rst_busy", 64'(busy_o), 64'(1));
    chk("rst_ack", 64'(flush_ack_o), 64'(0));
    chk("rst_wb_valid", 64'(wb_valid_o), 64'(0));
    chk("rst_tag_en_we", 64'({tag_en_o, tag_we_o}), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < NW; i++) begin
      #1;
      chk($sformatf("init_write_%0d", i), 64'({tag_en_o, tag_we_o, tag_addr_o, tag_bit_en_o, tag_wdata_o}),
          64'({1'b1, 1'b1, IW'(i), 10'h003, 10'h000}));
      @(negedge clk);
    end
    #1;
    chk("init_done_busy", 64'({busy_o, flush_ack_o}), 64'(2'b10));
    @(negedge clk); #1;
    chk("init_idle_busy", 64'({busy_o, flush_ack_o}), 64'(2'b00));
    for (int i = 0; i < NW; i++) chk($sformatf("init_tag%0d", i), 64'(tag_mem[i]), 64'(10'h3FC));

    // Table: preload image, mode, stall -> write-backs, ack latency, final store
    vecs[0].init_ts = '{ts(8'h01,0,1), ts(8'h02,0,1), ts(8'h03,0,1), ts(8'h04,0,1)};
    vecs[0].inv = 1'b0; vecs[0].stall = 0; vecs[0].exp_wbs = 0; vecs[0].exp_lat = 13;
    vecs[0].exp_addr0 = '0;
    vecs[0].exp_ts  = '{ts(8'h01,0,0), ts(8'h02,0,0), ts(8'h03,0,0), ts(8'h04,0,0)};

    vecs[1].init_ts = '{10'h0, 10'h0, ts(8'h5A,1,1), 10'h0};
    vecs[1].inv = 1'b0; vecs[1].stall = 5; vecs[1].exp_wbs = 1; vecs[1].exp_lat = 19;
    vecs[1].exp_addr0 = 16'h5A80;
    vecs[1].exp_ts  = '{10'h0, 10'h0, ts(8'h5A,0,0), 10'h0};

    vecs[2].init_ts = '{ts(8'h11,1,1), ts(8'hC3,0,1), 10'h0, ts(8'h33,1,1)};
    vecs[2].inv = 1'b0; vecs[2].stall = 0; vecs[2].exp_wbs = 2; vecs[2].exp_lat = 15;
    vecs[2].exp_addr0 = 16'h1100;
    vecs[2].exp_ts  = '{ts(8'h11,0,0), ts(8'hC3,0,0), 10'h0, ts(8'h33,0,0)};

    vecs[3].init_ts = '{ts(8'hA1,1,1), ts(8'hA2,1,1), ts(8'hA3,1,1), ts(8'hA4,1,1)};
    vecs[3].inv = 1'b1; vecs[3].stall = 0; vecs[3].exp_wbs = 0; vecs[3].exp_lat = 5;
    vecs[3].exp_addr0 = '0;
    vecs[3].exp_ts  = '{ts(8'hA1,0,0), ts(8'hA2,0,0), ts(8'hA3,0,0), ts(8'hA4,0,0)};

    vecs[4].init_ts = '{10'h0, ts(8'h77,1,0), 10'h0, 10'h0};
    vecs[4].inv = 1'b0; vecs[4].stall = 0; vecs[4].exp_wbs = 0; vecs[4].exp_lat = 13;
    vecs[4].exp_addr0 = '0;
    vecs[4].exp_ts  = '{10'h0, ts(8'h77,0,0), 10'h0, 10'h0};

    for (int r = 0; r < 5; r++) run_row(vecs[r], r);

    // Two requests mid-sweep coalesce into one invalidate-only sweep
    for (int i = 0; i < NW; i++) load(i, ts(8'h40, 0, 1), pat(9, i));
    @(negedge clk);
    flush_i = 1'b1; inv_only_i = 1'b0;
    ack1 = -1; ack2 = -1; acks = 0; den_after = 0; saw_wb = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      flush_i = (n == 3) || (n == 7);
      inv_only_i = (n == 7);
      if (wb_valid_o) saw_wb = 1'b1;
      if (acks == 1 && data_en_o) den_after++;
      if (n == 14) chk("pend_idle_busy", 64'(busy_o), 64'(1));
      if (flush_ack_o) begin
        acks++;
        if (acks == 1) ack1 = n; else ack2 = n;
      end
      if (acks == 2) break;
    end
    chk("coal_ack1", 64'(ack1), 64'(13));
    chk("coal_ack2", 64'(ack2), 64'(19));
    chk("coal_no_read", 64'(den_after), 64'(0));
    chk("coal_no_wb", 64'(saw_wb), 64'(0));
    @(negedge clk);
    chk("coal_busy_after", 64'(busy_o), 64'(0));

    // Reset during a stalled write-back, then a request during the reset sweep
    load(0, ts(8'h2B, 1, 1), pat(7, 0));
    @(negedge clk);
    flush_i = 1'b1; inv_only_i = 1'b0; wb_ready_i = 1'b0;
    saw_wb = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      flush_i = 1'b0;
      if (wb_valid_o) begin
        saw_wb = 1'b1;
        break;
      end
    end
    chk("rstwb_reached_wb", 64'(saw_wb), 64'(1));
    rst_ni = 1'b0;
    @(negedge clk); #1;
    chk("rstwb_valid_drop", 64'(wb_valid_o), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rstwb_restart_idx0", 64'({tag_we_o, tag_addr_o}), 64'({1'b1, 2'd0}));
    acks = 0; ack1 = -1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      flush_i = (n == 1); inv_only_i = 1'b1;
      if (wb_valid_o) saw_wb = 1'b0;
      if (flush_ack_o) begin
        acks++;
        ack1 = n;
      end
    end
    flush_i = 1'b0;
    chk("rstwb_ack_count", 64'(acks), 64'(1));
    chk("rstwb_ack_time", 64'(ack1), 64'(10));
    chk("rstwb_no_wb_after", 64'(saw_wb), 64'(1));
    chk("rstwb_line0", 64'(tag_mem[0]), 64'(ts(8'h2B, 0, 0)));
    chk("rstwb_idle", 64'(busy_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
